// File: rtl/sys_irq_ctrl.sv
// sys_irq_ctrl: Avalon-MM slave interrupt controller.
// Gathers up to 16 active-high irq sources into a single registered CPU irq.
// Each source has an enable, an edge/level mode and a pending bit, with
// software set/clear. A global enable gates the CPU irq.
// The register interface uses the timer's 16-bit, 3-bit address slave style.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select (0..7)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  16-bit write data
//   readdata   registered read data, 1-cycle latency, independent of chipselect
//   irq_in     source irq lines, synchronous to clk
//   irq        registered CPU interrupt request
module sys_irq_ctrl #(
  parameter int unsigned N_IRQ      = 8,
  parameter logic [15:0] EDGE_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq
);

  // Bits at or above N_IRQ are held at 0 in every register.
  localparam logic [16:0] MASK17 = (17'd1 << N_IRQ) - 17'd1;
  localparam logic [15:0] MASK   = MASK17[15:0];

  typedef enum logic [2:0] {
    A_STATUS  = 3'd0,
    A_PENDING = 3'd1,
    A_ENABLE  = 3'd2,
    A_EDGE    = 3'd3,
    A_ACTIVE  = 3'd4,
    A_VECTOR  = 3'd5,
    A_SET     = 3'd6,
    A_GLOBAL  = 3'd7
  } reg_addr_e;

  logic [15:0] irq_ext;
  logic [15:0] irq_d;
  logic [15:0] pending;
  logic [15:0] enable;
  logic [15:0] edge_mode;
  logic        global_en;

  logic        wr;
  logic [15:0] w1c;
  logic [15:0] setv;
  logic [15:0] rise;
  logic [15:0] pending_nxt;
  logic [15:0] active;
  logic [15:0] vector;
  logic [3:0]  vec_idx;
  logic [15:0] rd_mux;

  always_comb begin
    irq_ext              = '0;
    irq_ext[N_IRQ-1:0]   = irq_in;
  end

  assign wr   = chipselect & ~write_n;
  assign w1c  = (wr && address == A_PENDING) ? (writedata & MASK) : '0;
  assign setv = (wr && address == A_SET)     ? (writedata & MASK) : '0;
  assign rise = irq_ext & ~irq_d;

  // In edge mode, a new event (edge or SET) beats a W1C in the same cycle.
  // In level mode, the bit is loaded with irq_ext, so it always equals
  // irq_d. A switch from level to edge therefore keeps the current value.
  assign pending_nxt = ((((pending & ~w1c) | rise | setv) & edge_mode) |
                        (irq_ext & ~edge_mode)) & MASK;

  assign active = pending & enable;

  always_comb begin
    vec_idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (active[i-1]) vec_idx = 4'(i - 1);
    end
  end

  assign vector = {|active, 11'd0, vec_idx};

  always_comb begin
    rd_mux = '0;
    unique case (reg_addr_e'(address))
      A_STATUS:  rd_mux = irq_ext;
      A_PENDING: rd_mux = pending;
      A_ENABLE:  rd_mux = enable;
      A_EDGE:    rd_mux = edge_mode;
      A_ACTIVE:  rd_mux = active;
      A_VECTOR:  rd_mux = vector;
      A_SET:     rd_mux = '0;
      A_GLOBAL:  rd_mux = {15'd0, global_en};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d     <= '0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= EDGE_RESET & MASK;
      global_en <= 1'b0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      irq_d    <= irq_ext;
      pending  <= pending_nxt;
      readdata <= rd_mux;
      irq      <= global_en & |active;
      if (wr && address == A_ENABLE) enable    <= writedata & MASK;
      if (wr && address == A_EDGE)   edge_mode <= writedata & MASK;
      if (wr && address == A_GLOBAL) global_en <= writedata[0];
    end
  end

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed testbench for sys_irq_ctrl (N_IRQ=8, EDGE_RESET=16'h0081).
// Inputs change on the falling clock edge. Outputs are sampled on falling edges.
module tb_sys_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  sys_irq_ctrl #(
    .N_IRQ      (8),
    .EDGE_RESET (16'h0081)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; irq_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state: every register reads 0 except EDGE.
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), rd);
      chk($sformatf("reset_rd%0d", i), rd, (i == 3) ? 16'h0081 : 16'h0000);
    end
    chk("reset_irq", {15'd0, irq}, 16'h0000);

    // Edge source 0.
    write_reg(3'd3, 16'h0077);
    write_reg(3'd2, 16'h0001);
    write_reg(3'd7, 16'h0001);
    @(negedge clk); irq_in[0] = 1'b1;
    @(negedge clk); irq_in[0] = 1'b0;
    chk("edge0_irq_1cyc", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    chk("edge0_irq_2cyc", {15'd0, irq}, 16'h0001);
    read_reg(3'd1, rd); chk("edge0_pending", rd, 16'h0001);
    read_reg(3'd5, rd); chk("edge0_vector", rd, 16'h8000);
    write_reg(3'd1, 16'h0001);
    @(negedge clk);
    chk("edge0_w1c_irq", {15'd0, irq}, 16'h0000);

    // Level source 3.
    write_reg(3'd2, 16'h0009);
    @(negedge clk); irq_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    chk("lvl3_irq", {15'd0, irq}, 16'h0001);
    read_reg(3'd0, rd); chk("lvl3_status", rd, 16'h0008);
    read_reg(3'd5, rd); chk("lvl3_vector", rd, 16'h8003);
    write_reg(3'd1, 16'h0008);
    read_reg(3'd1, rd); chk("lvl3_w1c_ignored", rd, 16'h0008);
    @(negedge clk); irq_in[3] = 1'b0;
    @(negedge clk);
    chk("lvl3_drop_1cyc", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    chk("lvl3_drop_2cyc", {15'd0, irq}, 16'h0000);

    // Sources 2 and 5 together: lowest index wins.
    write_reg(3'd2, 16'h0024);
    @(negedge clk); irq_in[2] = 1'b1; irq_in[5] = 1'b1;
    @(negedge clk); irq_in[2] = 1'b0; irq_in[5] = 1'b0;
    read_reg(3'd4, rd); chk("pri_active", rd, 16'h0024);
    read_reg(3'd5, rd); chk("pri_vector_2", rd, 16'h8002);
    write_reg(3'd1, 16'h0004);
    read_reg(3'd5, rd); chk("pri_vector_5", rd, 16'h8005);
    write_reg(3'd1, 16'h0020);
    read_reg(3'd5, rd); chk("pri_vector_none", rd, 16'h0000);

    // An edge on source 1 in the same cycle as a W1C: the set wins.
    @(negedge clk);
    irq_in[1] = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h0002;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; irq_in[1] = 1'b0;
    read_reg(3'd1, rd); chk("collide_set_wins", rd, 16'h0002);
    write_reg(3'd1, 16'h0002);
    read_reg(3'd1, rd); chk("w1c_edge1", rd, 16'h0000);

    // Global enable gating, with the pending bit kept.
    write_reg(3'd2, 16'h0010);
    write_reg(3'd7, 16'h0000);
    @(negedge clk); irq_in[4] = 1'b1;
    @(negedge clk); irq_in[4] = 1'b0;
    repeat (2) @(negedge clk);
    chk("gbl_off_irq", {15'd0, irq}, 16'h0000);
    read_reg(3'd4, rd); chk("gbl_off_active", rd, 16'h0010);
    write_reg(3'd7, 16'h0001);
    @(negedge clk);
    chk("gbl_on_irq", {15'd0, irq}, 16'h0001);

    // SET writes and the unused upper bits.
    write_reg(3'd1, 16'h0010);
    write_reg(3'd2, 16'hFF40);
    read_reg(3'd2, rd); chk("enable_masked", rd, 16'h0040);
    @(negedge clk);
    chk("set_pre_irq", {15'd0, irq}, 16'h0000);
    write_reg(3'd6, 16'hFFC0);
    @(negedge clk);
    chk("set_irq", {15'd0, irq}, 16'h0001);
    read_reg(3'd5, rd); chk("set_vector", rd, 16'h8006);
    read_reg(3'd1, rd); chk("set_level_ignored", rd, 16'h0040);
    read_reg(3'd6, rd); chk("set_reads0", rd, 16'h0000);
    read_reg(3'd7, rd); chk("global_rd", rd, 16'h0001);

    // Reset while running. irq_in[0] stays high through the reset release.
    @(negedge clk);
    address = 3'd1; irq_in[0] = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("midrst_readdata", readdata, 16'h0000);
    chk("midrst_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    read_reg(3'd1, rd); chk("rst_release_edge", rd, 16'h0001);
    read_reg(3'd2, rd); chk("midrst_enable", rd, 16'h0000);
    read_reg(3'd3, rd); chk("midrst_edge", rd, 16'h0081);
    chk("midrst_irq_after", {15'd0, irq}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
